// File: rtl/extensor_16_32.sv
// Registered immediate extender.
// Turns an IN_WIDTH-bit instruction immediate into an OUT_WIDTH-bit operand
// in one of four formats (sign, zero, upper-half, branch offset). The result
// and its valid qualifier are registered, giving one cycle of latency at full
// throughput with no combinational path from inputs to outputs.
module extensor_16_32 #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [IN_WIDTH-1:0]  sinal16,
    output logic [OUT_WIDTH-1:0] sinal32,
    output logic                 out_valid
);

    localparam int EXT_WIDTH = OUT_WIDTH - IN_WIDTH;

    // Format encodings carried on the mode input.
    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;

    logic                 msb;
    logic [OUT_WIDTH-1:0] sign_ext;
    logic [OUT_WIDTH-1:0] zero_ext;
    logic [OUT_WIDTH-1:0] upper_ext;
    logic [OUT_WIDTH-1:0] branch_ext;
    logic [OUT_WIDTH-1:0] result_next;
    logic [OUT_WIDTH-1:0] result_reg;
    logic                 valid_reg;

    assign msb = sinal16[IN_WIDTH-1];

    // Build each format bit by bit: the low IN_WIDTH bits come straight from
    // the immediate, the extension bits are either the sign bit or zero.
    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_ext_bits
            if (gi < IN_WIDTH) begin : g_low
                assign sign_ext[gi] = sinal16[gi];
                assign zero_ext[gi] = sinal16[gi];
            end else begin : g_high
                assign sign_ext[gi] = msb;
                assign zero_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Upper-half format places the immediate in the top IN_WIDTH bits.
    assign upper_ext = {sinal16, {EXT_WIDTH{1'b0}}};

    // Branch offset is the sign-extended word scaled by 4; the two top bits
    // of the sign-extended value fall off the end.
    assign branch_ext = {sign_ext[OUT_WIDTH-3:0], 2'b00};

    // Select the requested format for the current transaction.
    always_comb begin
        result_next = sign_ext;
        case (mode_t'(mode))
            MODE_SIGN:   result_next = sign_ext;
            MODE_ZERO:   result_next = zero_ext;
            MODE_UPPER:  result_next = upper_ext;
            MODE_BRANCH: result_next = branch_ext;
            default:     result_next = sign_ext;
        endcase
    end

    // Output registers: reset clears, accepted input loads, idle holds data.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (in_valid) begin
            result_reg <= result_next;
            valid_reg  <= 1'b1;
        end else begin
            valid_reg  <= 1'b0;
        end
    end

    assign sinal32   = result_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_extensor_16_32.sv
// Self-checking bench for extensor_16_32. Each directed step drives one
// cycle of inputs, pushes the expected registered output onto a scoreboard
// queue, then pops and compares it against the DUT on the following falling
// edge.
module tb_extensor_16_32;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [1:0]  mode;
    logic [15:0] sinal16;
    logic [31:0] sinal32;
    logic        out_valid;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_held;
    int          checks;
    int          passed;

    extensor_16_32 #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .mode     (mode),
        .sinal16  (sinal16),
        .sinal32  (sinal32),
        .out_valid(out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference formatting written arithmetically.
    function automatic logic [31:0] ref_fmt(input logic [1:0] m, input logic [15:0] d);
        logic signed [31:0] sx;
        sx = 32'($signed(d));
        case (m)
            2'b00:   return sx;
            2'b01:   return {16'h0000, d};
            2'b10:   return {d, 16'h0000};
            default: return sx * 32'sd4;
        endcase
    endfunction

    // Drive one cycle, predict the registered result, then compare it.
    task automatic step(input logic r, input logic v, input logic [1:0] m,
                        input logic [15:0] d, input string tag);
        exp_t e;
        exp_t got;
        reset    = r;
        in_valid = v;
        mode     = m;
        sinal16  = d;
        if (r) begin
            model_held = 32'h0;
            e.valid    = 1'b0;
        end else if (v) begin
            model_held = ref_fmt(m, d);
            e.valid    = 1'b1;
        end else begin
            e.valid    = 1'b0;
        end
        e.data = model_held;
        e.tag  = tag;
        sb.push_back(e);
        @(negedge clock);
        got = sb.pop_front();
        checks++;
        assert (sinal32 === got.data) passed++;
        else $error("FAIL %s sinal32: got %h expected %h", got.tag, sinal32, got.data);
        checks++;
        assert (out_valid === got.valid) passed++;
        else $error("FAIL %s out_valid: got %b expected %b", got.tag, out_valid, got.valid);
        $display("step %-10s rst=%b v=%b mode=%b in=%h -> out=%h valid=%b",
                 tag, r, v, m, d, sinal32, out_valid);
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        model_held = 32'h0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        mode       = 2'b00;
        sinal16    = 16'h0000;

        // Reset then idle
        step(1'b1, 1'b0, 2'b00, 16'h0000, "reset");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b00, 16'hA5A5, "idle");

        // Sign mode, back to back
        step(1'b0, 1'b1, 2'b00, 16'h5555, "sign5555");
        step(1'b0, 1'b1, 2'b00, 16'hFD55, "signFD55");

        // Same input in every other mode, plus sign boundaries
        step(1'b0, 1'b1, 2'b01, 16'hFD55, "zeroFD55");
        step(1'b0, 1'b1, 2'b10, 16'hFD55, "upperFD55");
        step(1'b0, 1'b1, 2'b11, 16'hFD55, "branchFD55");
        step(1'b0, 1'b1, 2'b00, 16'h8000, "sign8000");
        step(1'b0, 1'b1, 2'b00, 16'h7FFF, "sign7FFF");
        step(1'b0, 1'b1, 2'b11, 16'h7FFF, "branch7FFF");
        step(1'b0, 1'b1, 2'b01, 16'hFFFF, "zeroFFFF");
        for (int m = 0; m < 4; m++) step(1'b0, 1'b1, 2'(m), 16'h0000, "zero_in");

        // Accept then idle: data holds, valid pulses once
        step(1'b0, 1'b1, 2'b00, 16'h1234, "sign1234");
        step(1'b0, 1'b0, 2'b11, 16'hFFFF, "hold1");
        step(1'b0, 1'b0, 2'b10, 16'h8000, "hold2");

        // Reset beats in_valid, then the same input is accepted
        step(1'b1, 1'b1, 2'b00, 16'hFFFF, "rst_prio");
        step(1'b0, 1'b1, 2'b00, 16'hFFFF, "signFFFF");

        // Random back-to-back stream with occasional idle cycles at the end
        for (int i = 0; i < 1000; i++)
            step(1'b0, 1'b1, 2'($urandom_range(3)), 16'($urandom), "rand");
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom_range(1)), 2'($urandom_range(3)), 16'($urandom), "rand_gap");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/extensor_16_32.md
Name: extensor_16_32

Overview:
- Registered immediate extender for the processor datapath.
- Takes a 16-bit immediate field from the instruction and produces a 32-bit operand for the ALU, address or branch logic.
- Supports sign, zero, upper-half and branch-offset (sign-extend, shift left 2) formats, selected per transaction.
- Output is registered: one clock of latency, with a valid qualifier.

Parameters:
- IN_WIDTH, 16, width of the input immediate.
- OUT_WIDTH, 32, width of the extended result. Must satisfy OUT_WIDTH >= IN_WIDTH + 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies sinal16 and mode in the current cycle.
- mode  input  2  extension format: 00 sign, 01 zero, 10 upper, 11 branch.
- sinal16  input  IN_WIDTH  immediate to extend.
- sinal32  output  OUT_WIDTH  registered extended result.
- out_valid  output  1  high for one cycle per accepted input, aligned with sinal32.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset:
  - On a rising edge with reset=1: sinal32 <= 0 and out_valid <= 0.
  - Reset has priority over in_valid in the same cycle.
  - Reset asserted mid-stream discards the pending input.
- Acceptance:
  - On a rising edge with reset=0 and in_valid=1, the formatted result is registered into sinal32 and out_valid <= 1.
  - Latency is exactly 1 cycle.
  - Full throughput: a new input may be accepted every cycle, with no backpressure.
- Idle:
  - On a rising edge with reset=0 and in_valid=0, sinal32 holds its previous value and out_valid <= 0.
- Format rules (s = sinal16, msb = s[IN_WIDTH-1]):
  - 00 sign: upper OUT_WIDTH-IN_WIDTH bits = msb replicated; low bits = s.
  - 01 zero: upper bits = 0; low bits = s.
  - 10 upper: s placed in bits [OUT_WIDTH-1 : OUT_WIDTH-IN_WIDTH]; all lower bits 0.
  - 11 branch: the sign-extended value shifted left by 2; the two LSBs are 0 and the top two bits of the sign-extended value are dropped (truncate to OUT_WIDTH).
- All four mode encodings are defined; there is no illegal mode.
- The result is a pure function of the current sinal16 and mode. There is no state other than the output registers.
- Boundary inputs:
  - 0x8000 and 0x7FFF must extend correctly in sign mode (most-negative and most-positive values).
  - 0x0000 yields 0 in every mode.
  - 0xFFFF yields all ones in sign mode.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then in_valid=0 for several cycles -> sinal32=0x00000000 and out_valid=0 throughout.
- Sign mode, sinal16=0x5555 then 0xFD55 on consecutive cycles -> sinal32=0x00005555 one cycle after the first, 0xFFFFFD55 the next cycle; out_valid=1 for both.
- Same input 0xFD55 in each mode -> zero 0x0000FD55; upper 0xFD550000; branch 0xFFFFF554. Sign-mode boundaries: 0x8000 -> 0xFFFF8000, 0x7FFF -> 0x00007FFF.
- Accept 0x1234 (sign), then drop in_valid -> sinal32 stays 0x00001234; out_valid pulses high for exactly one cycle.
- Assert reset in the same cycle as in_valid=1, sinal16=0xFFFF -> next sinal32=0, out_valid=0. After deassert, the same input yields 0xFFFFFFFF.
- Random back-to-back stream of 1000 inputs with random modes -> every output matches the reference model with exactly 1-cycle latency.
